// File: rtl/ahb_pkg.sv
// ============================================================================
// ahb_pkg : AHB-Lite transfer encodings and helpers shared across AHB blocks
// Rev 1.0
// ============================================================================
`default_nettype none

package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } htrans_e;

    function automatic int calc_mw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // SEQ and BUSY both mean a burst is still running on the owner's port
    function automatic logic burst_active(input logic [1:0] trans);
        return (trans == HTRANS_SEQ) || (trans == HTRANS_BUSY);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_bus_arbiter_if.sv
// ============================================================================
// ahb_bus_arbiter_if : requester-side and bridge-side bus of the AHB arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface ahb_bus_arbiter_if
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 3
);
    localparam int MW = calc_mw(NUM_MASTERS);

    logic [NUM_MASTERS-1:0]    hbusreq;
    logic [NUM_MASTERS-1:0]    hlock;
    logic [2*NUM_MASTERS-1:0]  htrans_m;
    logic [32*NUM_MASTERS-1:0] haddr_m;
    logic [NUM_MASTERS-1:0]    hwrite_m;
    logic [32*NUM_MASTERS-1:0] hwdata_m;
    logic                      hready_in;

    logic [NUM_MASTERS-1:0]    hgrant;
    logic [MW-1:0]             hmaster;
    logic                      hmastlock;
    logic [1:0]                htrans;
    logic [31:0]               haddr;
    logic                      hwrite;
    logic [31:0]               hwdata;

    // master: the requesters plus the bridge ready feedback
    modport master (
        output hbusreq, hlock, htrans_m, haddr_m, hwrite_m, hwdata_m, hready_in,
        input  hgrant, hmaster, hmastlock, htrans, haddr, hwrite, hwdata
    );

    // slave: the arbiter itself
    modport slave (
        input  hbusreq, hlock, htrans_m, haddr_m, hwrite_m, hwdata_m, hready_in,
        output hgrant, hmaster, hmastlock, htrans, haddr, hwrite, hwdata
    );

endinterface

`default_nettype wire

// File: rtl/ahb_bus_arbiter_rr_picker.sv
// ============================================================================
// rr_picker : round-robin search of a request vector starting after a pointer
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_picker
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int MW          = calc_mw(NUM_MASTERS)
) (
    input  wire logic [NUM_MASTERS-1:0] i_req,
    input  wire logic [MW-1:0]          i_ptr,
    output logic      [MW-1:0]          o_winner,
    output logic                        o_valid
);

    int w_idx;

    // Walk from farthest to nearest so the nearest requester after the pointer wins
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_idx    = 0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            w_idx = (int'(i_ptr) + i) % NUM_MASTERS;
            if (i_req[w_idx]) begin
                o_winner = MW'(w_idx);
                o_valid  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ahb_bus_arbiter.sv
// ============================================================================
// ahb_bus_arbiter : round-robin AHB-Lite arbiter and address/data multiplexer
// Rev 1.0
// ============================================================================
`default_nettype none

module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 3,
    parameter int DEFAULT_MASTER = 0
) (
    input wire logic         hclk,
    input wire logic         hresetn,
    ahb_bus_arbiter_if.slave bus
);

    localparam int                   MW         = calc_mw(NUM_MASTERS);
    localparam logic [MW-1:0]          C_DEFAULT  = MW'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] C_ONE      = NUM_MASTERS'(1);

    logic [NUM_MASTERS-1:0] r_hgrant;
    logic [MW-1:0]          r_hmaster;
    logic [MW-1:0]          r_data_owner;
    logic [MW-1:0]          r_ptr;
    logic                   r_hmastlock;

    logic [MW-1:0]          w_winner;
    logic                   w_valid;
    logic [MW-1:0]          w_next;
    logic [1:0]             w_owner_trans;
    logic                   w_owner_lock;
    logic                   w_hold;

    rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .MW          (MW)
    ) u_rr_picker (
        .i_req    (bus.hbusreq),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    always_comb begin
        w_owner_trans = bus.htrans_m[2*int'(r_hmaster) +: 2];
        w_owner_lock  = bus.hlock[r_hmaster];
        w_hold        = (r_hmastlock && w_owner_lock) || burst_active(w_owner_trans);
        w_next        = w_valid ? w_winner : C_DEFAULT;
    end

    // Every register freezes while the bridge stretches the data phase
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            r_hgrant     <= C_ONE << C_DEFAULT;
            r_hmaster    <= C_DEFAULT;
            r_data_owner <= C_DEFAULT;
            r_ptr        <= C_DEFAULT;
            r_hmastlock  <= 1'b0;
        end else if (bus.hready_in) begin
            r_data_owner <= r_hmaster;
            r_hmastlock  <= w_owner_lock;
            if (!w_hold) begin
                r_hmaster <= w_next;
                r_hgrant  <= C_ONE << w_next;
                if (w_next != r_hmaster) begin
                    r_ptr <= w_next;
                end
            end
        end
    end

    assign bus.hgrant    = r_hgrant;
    assign bus.hmaster   = r_hmaster;
    assign bus.hmastlock = r_hmastlock;
    assign bus.htrans    = bus.htrans_m[2*int'(r_hmaster) +: 2];
    assign bus.haddr     = bus.haddr_m[32*int'(r_hmaster) +: 32];
    assign bus.hwrite    = bus.hwrite_m[r_hmaster];
    assign bus.hwdata    = bus.hwdata_m[32*int'(r_data_owner) +: 32];

endmodule

`default_nettype wire
